// File: rtl/nv_nvdla_nocif_dram_wr_resp.sv
// AXI write-channel responder: queues AW bursts, writes each W beat straight to a flat
// memory port and returns one in-order B response per completed burst.
module nv_nvdla_nocif_dram_wr_resp #(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DATA_W   = 512,
    parameter int unsigned AW_DEPTH = 4,
    parameter int unsigned B_DEPTH  = 4
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  mcif2noc_axi_aw_awvalid,
    output logic                  mcif2noc_axi_aw_awready,
    input  logic [7:0]            mcif2noc_axi_aw_awid,
    input  logic [3:0]            mcif2noc_axi_aw_awlen,
    input  logic [ADDR_W-1:0]     mcif2noc_axi_aw_awaddr,
    input  logic                  mcif2noc_axi_w_wvalid,
    output logic                  mcif2noc_axi_w_wready,
    input  logic [DATA_W-1:0]     mcif2noc_axi_w_wdata,
    input  logic [DATA_W/8-1:0]   mcif2noc_axi_w_wstrb,
    input  logic                  mcif2noc_axi_w_wlast,
    output logic                  noc2mcif_axi_b_bvalid,
    input  logic                  noc2mcif_axi_b_bready,
    output logic [7:0]            noc2mcif_axi_b_bid,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  wlast_err,
    output logic [7:0]            aw_os_cnt
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned AW_PW  = $clog2(AW_DEPTH);
    localparam int unsigned B_PW   = $clog2(B_DEPTH);
    localparam int unsigned AW_CW  = AW_PW + 1;
    localparam int unsigned B_CW   = B_PW + 1;
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(STRB_W);

    typedef enum logic {StIdle, StData} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic               err_q, err_set;
    logic               rdy_q;

    logic [7:0]         aw_id_mem   [AW_DEPTH];
    logic [3:0]         aw_len_mem  [AW_DEPTH];
    logic [ADDR_W-1:0]  aw_addr_mem [AW_DEPTH];
    logic [AW_PW-1:0]   aw_wptr_q, aw_rptr_q;
    logic [AW_CW-1:0]   aw_cnt_q;
    logic [7:0]         b_id_mem [B_DEPTH];
    logic [B_PW-1:0]    b_wptr_q, b_rptr_q;
    logic [B_CW-1:0]    b_cnt_q;

    logic aw_push, burst_end, b_pop, wready, beat_acc, len_hit;
    logic [8:0] os_sum;

    // AW acceptance is held off until the first edge after reset release
    assign mcif2noc_axi_aw_awready = rdy_q && (aw_cnt_q != AW_CW'(AW_DEPTH));
    assign aw_push = mcif2noc_axi_aw_awvalid && mcif2noc_axi_aw_awready;
    assign noc2mcif_axi_b_bvalid = (b_cnt_q != '0);
    assign b_pop = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;
    assign noc2mcif_axi_b_bid = noc2mcif_axi_b_bvalid ? b_id_mem[b_rptr_q] : 8'h00;
    assign mcif2noc_axi_w_wready = wready;
    assign mem_we = beat_acc;
    assign mem_addr = beat_acc ? cur_addr_q : '0;
    assign mem_wdata = beat_acc ? mcif2noc_axi_w_wdata : '0;
    assign mem_wstrb = beat_acc ? mcif2noc_axi_w_wstrb : '0;
    assign wlast_err = err_q;
    assign os_sum = 9'(aw_cnt_q) + 9'(b_cnt_q);
    assign aw_os_cnt = (os_sum > 9'd255) ? 8'hFF : os_sum[7:0];

    // Burst sequencing: load head AW in idle, stream beats in data, close on len or wlast
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        beat_cnt_d = beat_cnt_q;
        wready     = 1'b0;
        beat_acc   = 1'b0;
        burst_end  = 1'b0;
        err_set    = 1'b0;
        len_hit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (aw_cnt_q != '0) begin
                    state_d    = StData;
                    cur_addr_d = aw_addr_mem[aw_rptr_q];
                    beat_cnt_d = 4'd0;
                end
            end
            StData: begin
                // Stall every beat while B is full so the closing beat always has a slot
                wready   = (b_cnt_q < B_CW'(B_DEPTH));
                beat_acc = mcif2noc_axi_w_wvalid && wready;
                if (beat_acc) begin
                    cur_addr_d = cur_addr_q + BEAT_BYTES;
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    len_hit    = (beat_cnt_q == aw_len_mem[aw_rptr_q]);
                    if (len_hit || mcif2noc_axi_w_wlast) begin
                        burst_end = 1'b1;
                        state_d   = StIdle;
                    end
                    err_set = len_hit ^ mcif2noc_axi_w_wlast;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, counters and FIFO pointers
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
            aw_wptr_q  <= '0;
            aw_rptr_q  <= '0;
            aw_cnt_q   <= '0;
            b_wptr_q   <= '0;
            b_rptr_q   <= '0;
            b_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_q | err_set;
            rdy_q      <= 1'b1;
            if (aw_push)   aw_wptr_q <= aw_wptr_q + 1'b1;
            if (burst_end) aw_rptr_q <= aw_rptr_q + 1'b1;
            if (aw_push && !burst_end)      aw_cnt_q <= aw_cnt_q + 1'b1;
            else if (!aw_push && burst_end) aw_cnt_q <= aw_cnt_q - 1'b1;
            if (burst_end) b_wptr_q <= b_wptr_q + 1'b1;
            if (b_pop)     b_rptr_q <= b_rptr_q + 1'b1;
            if (burst_end && !b_pop)      b_cnt_q <= b_cnt_q + 1'b1;
            else if (!burst_end && b_pop) b_cnt_q <= b_cnt_q - 1'b1;
        end
    end

    // FIFO storage; contents are only observed through valid counts
    always_ff @(posedge nvdla_core_clk) begin
        if (aw_push) begin
            aw_id_mem[aw_wptr_q]   <= mcif2noc_axi_aw_awid;
            aw_len_mem[aw_wptr_q]  <= mcif2noc_axi_aw_awlen;
            aw_addr_mem[aw_wptr_q] <= mcif2noc_axi_aw_awaddr;
        end
        if (burst_end) begin
            b_id_mem[b_wptr_q] <= aw_id_mem[aw_rptr_q];
        end
    end

endmodule

// File: tb/tb_nv_nvdla_nocif_dram_wr_resp.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model (queues of open bursts and pending responses).
module tb_nv_nvdla_nocif_dram_wr_resp;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int STRB_W = DATA_W / 8;
    localparam int NRAND  = 40;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic awvalid = 1'b0, awready;
    logic [7:0] awid = '0;
    logic [3:0] awlen = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic wvalid = 1'b0, wready, wlast = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic [STRB_W-1:0] wstrb = '0;
    logic bvalid, bready = 1'b0;
    logic [7:0] bid;
    logic mem_we, wlast_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [7:0] aw_os_cnt;

    nv_nvdla_nocif_dram_wr_resp dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rstn        (rstn),
        .mcif2noc_axi_aw_awvalid(awvalid),
        .mcif2noc_axi_aw_awready(awready),
        .mcif2noc_axi_aw_awid   (awid),
        .mcif2noc_axi_aw_awlen  (awlen),
        .mcif2noc_axi_aw_awaddr (awaddr),
        .mcif2noc_axi_w_wvalid  (wvalid),
        .mcif2noc_axi_w_wready  (wready),
        .mcif2noc_axi_w_wdata   (wdata),
        .mcif2noc_axi_w_wstrb   (wstrb),
        .mcif2noc_axi_w_wlast   (wlast),
        .noc2mcif_axi_b_bvalid  (bvalid),
        .noc2mcif_axi_b_bready  (bready),
        .noc2mcif_axi_b_bid     (bid),
        .mem_we                 (mem_we),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_wstrb              (mem_wstrb),
        .wlast_err              (wlast_err),
        .aw_os_cnt              (aw_os_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]        id;
        logic [3:0]        len;
        logic [ADDR_W-1:0] addr;
        int                beats;
    } burst_t;

    burst_t     m_aw[$];   // accepted bursts not yet closed, in order
    logic [7:0] m_b[$];    // closed bursts awaiting B
    bit         m_err = 1'b0;
    int         rel_edges = 0;
    logic [ADDR_W-1:0] mem_log[$];
    logic [7:0]        bid_log[$];
    bit         b_rand = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/violation expected none", name);
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Edges seen since reset release; AW acceptance opens after the first one
    always @(posedge clk or negedge rstn) begin
        if (!rstn) rel_edges <= 0;
        else if (rel_edges < 2) rel_edges <= rel_edges + 1;
    end

    always @(posedge clk) begin
        if (b_rand) begin
            #1;
            bready = ($urandom_range(0, 3) != 0);
        end
    end

    // Compare process: checks outputs against model state, then advances the model
    // by the handshakes that will complete at the coming edge
    always @(negedge clk) begin
        burst_t h;
        logic hit;
        logic [ADDR_W-1:0] ea;
        if (!rstn) begin
            chk("rst_awready", awready, 0);
            chk("rst_wready", wready, 0);
            chk("rst_bvalid", bvalid, 0);
            chk("rst_bid", bid, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wstrb", mem_wstrb, 0);
            chk("rst_wlast_err", wlast_err, 0);
            chk("rst_aw_os_cnt", aw_os_cnt, 0);
            m_aw.delete();
            m_b.delete();
            m_err = 1'b0;
        end else begin
            chk("aw_os_cnt", aw_os_cnt, m_aw.size() + m_b.size());
            chk("awready", awready, (rel_edges >= 1) && (m_aw.size() < 4));
            chk("bvalid", bvalid, m_b.size() != 0);
            chk("wlast_err", wlast_err, m_err);
            if (bvalid && m_b.size() != 0) chk("bid", bid, m_b[0]);
            if (wready && (m_aw.size() == 0 || m_b.size() >= 4)) fail("wready_without_room");
            chk("mem_we", mem_we, wvalid && wready);
            if (wvalid && wready && m_aw.size() != 0) begin
                h  = m_aw[0];
                ea = h.addr + ADDR_W'(h.beats * STRB_W);
                chk("mem_addr", mem_addr, ea);
                chk("mem_wdata", mem_wdata, wdata);
                chk("mem_wstrb", mem_wstrb, wstrb);
                mem_log.push_back(mem_addr);
                hit = (h.beats == int'(h.len));
                if (hit != wlast) m_err = 1'b1;
                h.beats++;
                m_aw[0] = h;
                if (hit || wlast) begin
                    m_b.push_back(h.id);
                    void'(m_aw.pop_front());
                end
            end
            if (bvalid && bready && m_b.size() != 0) begin
                bid_log.push_back(bid);
                void'(m_b.pop_front());
            end
            if (awvalid && awready) m_aw.push_back('{awid, awlen, awaddr, 0});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [3:0] len,
                           input logic [ADDR_W-1:0] addr);
        bit hs = 1'b0;
        awvalid = 1'b1; awid = id; awlen = len; awaddr = addr;
        for (int i = 0; i < 400 && !hs; i++) begin
            @(negedge clk);
            hs = awready;
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        if (!hs) fail("aw_handshake");
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                             input logic last);
        bit hs = 1'b0;
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
        for (int i = 0; i < 400 && !hs; i++) begin
            @(negedge clk);
            hs = wready;
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (!hs) fail("w_handshake");
    endtask

    // lastpos < 0 means no beat carries wlast
    task automatic send_burst(input int nbeats, input int lastpos, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step($urandom_range(1, 3));
            send_beat(rand_data(), {$urandom, $urandom}, i == lastpos);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = (m_aw.size() == 0) && (m_b.size() == 0) && !bvalid;
            @(posedge clk);
            #1;
        end
        if (!done) fail("drain");
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        step(3);
        rstn = 1'b1;
        step(2);
        mem_log.delete();
        bid_log.delete();
    endtask

    int p_len[NRAND], p_nb[NRAND], p_last[NRAND];
    logic [7:0] p_id[NRAND];
    logic [ADDR_W-1:0] p_addr[NRAND];

    initial begin
        // Reset and first-cycle-after-release behaviour
        step(2);
        chk("awready_in_reset", awready, 0);
        rstn = 1'b1;
        #2;
        chk("awready_before_edge", awready, 0);
        step(1);
        chk("awready_after_release", awready, 1);
        step(1);

        // Single 4-beat burst
        mem_log.delete(); bid_log.delete();
        send_aw(8'h05, 4'd3, 64'h1000);
        send_burst(4, 3, 1'b0);
        wait_idle();
        chk("t1_beats", mem_log.size(), 4);
        if (mem_log.size() == 4) begin
            chk("t1_a0", mem_log[0], 64'h1000);
            chk("t1_a1", mem_log[1], 64'h1040);
            chk("t1_a2", mem_log[2], 64'h1080);
            chk("t1_a3", mem_log[3], 64'h10C0);
        end
        chk("t1_nb", bid_log.size(), 1);
        if (bid_log.size() == 1) chk("t1_bid", bid_log[0], 8'h05);
        chk("t1_err", wlast_err, 0);

        // len=0 without wlast
        mem_log.delete();
        send_aw(8'h21, 4'd0, 64'h2000);
        send_burst(1, -1, 1'b0);
        wait_idle();
        chk("t3a_beats", mem_log.size(), 1);
        chk("t3a_err", wlast_err, 1);
        do_reset();
        chk("t3_err_cleared", wlast_err, 0);

        // len=2 with early wlast on second beat
        send_aw(8'h22, 4'd2, 64'h3000);
        send_burst(2, 1, 1'b0);
        wait_idle();
        chk("t3b_beats", mem_log.size(), 2);
        chk("t3b_err", wlast_err, 1);
        do_reset();

        // Address wrap at top of space
        send_aw(8'h33, 4'd1, 64'hFFFF_FFFF_FFFF_FFC0);
        send_burst(2, 1, 1'b0);
        wait_idle();
        chk("t6_beats", mem_log.size(), 2);
        if (mem_log.size() == 2) begin
            chk("t6_a0", mem_log[0], 64'hFFFF_FFFF_FFFF_FFC0);
            chk("t6_a1", mem_log[1], 64'h0);
        end

        // W presented well before its AW
        mem_log.delete();
        fork
            send_burst(1, 0, 1'b0);
            begin
                step(5);
                chk("t4_no_write_early", mem_log.size(), 0);
                send_aw(8'h44, 4'd0, 64'h4440);
            end
        join
        wait_idle();
        chk("t4_beats", mem_log.size(), 1);
        if (mem_log.size() == 1) chk("t4_addr", mem_log[0], 64'h4440);

        // Back-pressure: AW fills, then B fills and stalls W
        bready = 1'b0;
        bid_log.delete();
        for (int i = 0; i < 4; i++) send_aw(8'h11 + 8'(i), 4'd0, 64'h8000 + 64'(i * 64));
        step(1);
        chk("t2_awready_full", awready, 0);
        chk("t2_os4", aw_os_cnt, 4);
        for (int i = 0; i < 4; i++) send_burst(1, 0, 1'b0);
        send_aw(8'h15, 4'd0, 64'h9000);
        wvalid = 1'b1; wlast = 1'b1; wdata = rand_data(); wstrb = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_wready_stall", wready, 0);
            @(posedge clk);
            #1;
        end
        chk("t2_os5", aw_os_cnt, 5);
        bready = 1'b1;
        send_beat(wdata, wstrb, 1'b1);
        wait_idle();
        chk("t2_nb", bid_log.size(), 5);
        if (bid_log.size() == 5)
            for (int i = 0; i < 5; i++) chk("t2_bid_order", bid_log[i], 8'h11 + 8'(i));

        // Reset mid-burst, then a clean burst
        send_aw(8'h55, 4'd3, 64'h5000);
        send_burst(2, -1, 1'b0);
        wvalid = 1'b1;
        rstn = 1'b0;
        #1;
        chk("t5_mem_we", mem_we, 0);
        chk("t5_os", aw_os_cnt, 0);
        chk("t5_wready", wready, 0);
        do_reset();
        send_aw(8'h56, 4'd1, 64'h6000);
        send_burst(2, 1, 1'b0);
        wait_idle();
        chk("t5_beats", mem_log.size(), 2);
        if (mem_log.size() == 2) chk("t5_a1", mem_log[1], 64'h6040);
        chk("t5_err", wlast_err, 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < NRAND; i++) begin
            int mode;
            p_id[i]   = 8'($urandom);
            p_len[i]  = $urandom_range(0, 7);
            p_addr[i] = {$urandom, $urandom} & ~64'h3F;
            mode = $urandom_range(0, 9);
            p_nb[i] = p_len[i] + 1;
            p_last[i] = p_len[i];
            if (mode == 0 && p_len[i] > 0) begin
                p_last[i] = $urandom_range(0, p_len[i] - 1);
                p_nb[i] = p_last[i] + 1;
            end else if (mode == 1) begin
                p_last[i] = -1;
            end
        end
        b_rand = 1'b1;
        fork
            for (int i = 0; i < NRAND; i++) begin
                if ($urandom_range(0, 2) == 0) step($urandom_range(1, 4));
                send_aw(p_id[i], 4'(p_len[i]), p_addr[i]);
            end
            for (int i = 0; i < NRAND; i++) send_burst(p_nb[i], p_last[i], 1'b1);
        join
        b_rand = 1'b0;
        step(1);
        wait_idle();
        chk("rand_all_bids", bid_log.size(), NRAND);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
